// File: rtl/bomb_pkg.sv
// ---------------------------------------------------------------------------
// bomb_pkg
//   Shared types for the bomb array controller: the per-channel state
//   enumeration and a small decode helper used by the channel outputs.
// ---------------------------------------------------------------------------
package bomb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_PAUSE,
    S_EXPLODE,
    S_SAVED
  } bomb_state_t;

  // A bomb counts as active from the arm cycle until it reaches an outcome.
  function automatic logic is_active(input bomb_state_t st);
    return (st == S_ARM) || (st == S_RUN) || (st == S_PAUSE);
  endfunction

endpackage

// File: rtl/bomb_channel.sv
// ---------------------------------------------------------------------------
// bomb_channel
//   One independent time-bomb: countdown register, pause-window counter and
//   the IDLE/ARM/RUN/PAUSE/EXPLODE/SAVED state machine.
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   OneSecPulse    : shared one-cycle seconds tick
//   arm            : start request (IDLE only), loads load_val
//   load_val       : initial countdown in seconds
//   pause          : enter a pause window (RUN only)
//   save           : defuse (RUN/PAUSE only)
//   clear          : return from EXPLODE/SAVED to IDLE
//   remaining      : current countdown value
//   active/explode/saved : Moore state decodes
// ---------------------------------------------------------------------------
module bomb_channel
  import bomb_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PAUSE_SEC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             OneSecPulse,
  input  logic             arm,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pause,
  input  logic             save,
  input  logic             clear,
  output logic [CNT_W-1:0] remaining,
  output logic             active,
  output logic             explode,
  output logic             saved
);

  localparam int unsigned PW = (PAUSE_SEC > 1) ? $clog2(PAUSE_SEC) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PAUSE_SEC - 1);

  bomb_state_t      r_state;
  bomb_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [PW-1:0]    r_pcnt;
  logic [PW-1:0]    w_pcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pcnt_nxt  = r_pcnt;
    unique case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_state_nxt = S_ARM;
          w_count_nxt = load_val;
        end
      end
      S_ARM: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // save beats an expired count, which beats pause, which beats the tick
        if (save) begin
          w_state_nxt = S_SAVED;
        end else if (r_count == '0) begin
          w_state_nxt = S_EXPLODE;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
          w_pcnt_nxt  = '0;
        end else if (OneSecPulse && (r_count != '0)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (save) begin
          w_state_nxt = S_SAVED;
        end else if (OneSecPulse) begin
          if (r_pcnt == PCNT_LAST) begin
            w_state_nxt = S_RUN;
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
      end
      S_EXPLODE, S_SAVED: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_pcnt_nxt  = '0;
      end
    endcase
  end

  assign remaining = r_count;
  assign active    = is_active(r_state);
  assign explode   = (r_state == S_EXPLODE);
  assign saved     = (r_state == S_SAVED);

endmodule

// File: rtl/bomb_array_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_array_ctrl
//   N_BOMBS independent time-bomb channels sharing one seconds tick.
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   OneSecPulse    : shared one-cycle seconds tick
//   arm/pause/save/clear : per-bomb game events, one bit per channel
//   load_val       : per-bomb initial seconds, bomb k at [k*CNT_W +: CNT_W]
//   remaining      : per-bomb countdown, same packing as load_val
//   active/explode/saved : per-bomb state decodes
//   any_explode    : registered OR of explode (one cycle behind)
// ---------------------------------------------------------------------------
module bomb_array_ctrl
  import bomb_pkg::*;
#(
  parameter int unsigned N_BOMBS   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PAUSE_SEC = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     OneSecPulse,
  input  logic [N_BOMBS-1:0]       arm,
  input  logic [N_BOMBS*CNT_W-1:0] load_val,
  input  logic [N_BOMBS-1:0]       pause,
  input  logic [N_BOMBS-1:0]       save,
  input  logic [N_BOMBS-1:0]       clear,
  output logic [N_BOMBS*CNT_W-1:0] remaining,
  output logic [N_BOMBS-1:0]       active,
  output logic [N_BOMBS-1:0]       explode,
  output logic [N_BOMBS-1:0]       saved,
  output logic                     any_explode
);

  logic [N_BOMBS-1:0] w_explode;
  logic               r_any_explode;

  for (genvar g = 0; g < N_BOMBS; g++) begin : g_ch
    bomb_channel #(
      .CNT_W    (CNT_W),
      .PAUSE_SEC(PAUSE_SEC)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .OneSecPulse(OneSecPulse),
      .arm        (arm[g]),
      .load_val   (load_val[g*CNT_W +: CNT_W]),
      .pause      (pause[g]),
      .save       (save[g]),
      .clear      (clear[g]),
      .remaining  (remaining[g*CNT_W +: CNT_W]),
      .active     (active[g]),
      .explode    (w_explode[g]),
      .saved      (saved[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_any_explode <= 1'b0;
    else       r_any_explode <= |w_explode;
  end

  assign explode     = w_explode;
  assign any_explode = r_any_explode;

endmodule

// File: tb/tb_bomb_array_ctrl.sv
module tb_bomb_array_ctrl;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PS = 3;

  // reference model phases
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_PAUSE = 3, P_BOOM = 4, P_SAFE = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           OneSecPulse;
  logic [N-1:0]   arm, pause, save, clear;
  logic [N*W-1:0] load_val;
  logic [N*W-1:0] remaining;
  logic [N-1:0]   active, explode, saved;
  logic           any_explode;

  int checks   = 0;
  int failures = 0;

  // model state: phase, countdown, pause ticks still to wait
  int m_ph[N];
  int m_cnt[N];
  int m_left[N];
  bit m_any;

  bomb_array_ctrl #(.N_BOMBS(N), .CNT_W(W), .PAUSE_SEC(PS)) dut (
    .clk(clk), .reset(reset), .OneSecPulse(OneSecPulse),
    .arm(arm), .load_val(load_val), .pause(pause), .save(save), .clear(clear),
    .remaining(remaining), .active(active), .explode(explode), .saved(saved),
    .any_explode(any_explode)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit nx_any;
    nx_any = 1'b0;
    for (int k = 0; k < N; k++) if (m_ph[k] == P_BOOM) nx_any = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_ph[k] = P_IDLE; m_cnt[k] = 0; m_left[k] = 0;
      end else begin
        case (m_ph[k])
          P_IDLE:  if (arm[k]) begin m_ph[k] = P_ARM; m_cnt[k] = int'(load_val[k*W +: W]); end
          P_ARM:   m_ph[k] = P_RUN;
          P_RUN: begin
            if (save[k]) m_ph[k] = P_SAFE;
            else if (m_cnt[k] == 0) m_ph[k] = P_BOOM;
            else if (pause[k]) begin m_ph[k] = P_PAUSE; m_left[k] = PS; end
            else if (OneSecPulse) m_cnt[k] = m_cnt[k] - 1;
          end
          P_PAUSE: begin
            if (save[k]) m_ph[k] = P_SAFE;
            else if (OneSecPulse) begin
              m_left[k] = m_left[k] - 1;
              if (m_left[k] == 0) m_ph[k] = P_RUN;
            end
          end
          default: if (clear[k]) begin m_ph[k] = P_IDLE; m_cnt[k] = 0; end
        endcase
      end
    end
    m_any = reset ? 1'b0 : nx_any;
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    OneSecPulse = 1'b1;
    tick_clk();
    OneSecPulse = 1'b0;
  endtask

  task automatic idle_inputs();
    arm = '0; pause = '0; save = '0; clear = '0; OneSecPulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); load_val = '0;
    arm[0] = 1'b1; load_val[0 +: W] = 8'd5;
    for (int i = 0; i < N; i++) begin m_ph[i] = P_IDLE; m_cnt[i] = 0; m_left[i] = 0; end
    m_any = 1'b0;
    tick_clk(); tick_clk();
    checks++; if (remaining !== '0) begin failures++; $display("FAIL reset_remaining got=%h exp=0", remaining); end
    checks++; if (active !== '0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (explode !== '0) begin failures++; $display("FAIL reset_explode got=%b exp=0", explode); end
    checks++; if (saved !== '0) begin failures++; $display("FAIL reset_saved got=%b exp=0", saved); end
    checks++; if (any_explode !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", any_explode); end
    reset = 1'b0; arm = '0;
    tick_clk();
    checks++; if (active[0] !== 1'b0) begin failures++; $display("FAIL reset_arm_ignored got=%b exp=0", active[0]); end
  endtask

  task automatic test_countdown();
    load_val[0 +: W] = 8'd3; arm[0] = 1'b1;
    tick_clk(); arm = '0;
    checks++; if (active[0] !== 1'b1) begin failures++; $display("FAIL cd_active got=%b exp=1", active[0]); end
    checks++; if (remaining[0 +: W] !== 8'd3) begin failures++; $display("FAIL cd_load got=%0d exp=3", remaining[0 +: W]); end
    tick_clk();
    for (int e = 2; e >= 0; e--) begin
      pulse_tick();
      checks++; if (remaining[0 +: W] !== W'(e)) begin failures++; $display("FAIL cd_count got=%0d exp=%0d", remaining[0 +: W], e); end
    end
    checks++; if (explode[0] !== 1'b0) begin failures++; $display("FAIL cd_explode_early got=%b exp=0", explode[0]); end
    tick_clk();
    checks++; if (explode[0] !== 1'b1) begin failures++; $display("FAIL cd_explode got=%b exp=1", explode[0]); end
    checks++; if (any_explode !== 1'b0) begin failures++; $display("FAIL cd_any_lag got=%b exp=0", any_explode); end
    tick_clk();
    checks++; if (any_explode !== 1'b1) begin failures++; $display("FAIL cd_any got=%b exp=1", any_explode); end
    clear[0] = 1'b1; tick_clk(); clear = '0;
    checks++; if (explode[0] !== 1'b0) begin failures++; $display("FAIL cd_clear got=%b exp=0", explode[0]); end
    tick_clk();
    checks++; if (any_explode !== 1'b0) begin failures++; $display("FAIL cd_any_clear got=%b exp=0", any_explode); end
  endtask

  task automatic test_pause();
    load_val[1*W +: W] = 8'd10; arm[1] = 1'b1;
    tick_clk(); arm = '0; tick_clk();
    pulse_tick(); pulse_tick();
    checks++; if (remaining[1*W +: W] !== 8'd8) begin failures++; $display("FAIL pause_pre got=%0d exp=8", remaining[1*W +: W]); end
    pause[1] = 1'b1; tick_clk(); pause = '0;
    for (int t = 0; t < 3; t++) begin
      pulse_tick();
      checks++; if (remaining[1*W +: W] !== 8'd8) begin failures++; $display("FAIL pause_frozen tick%0d got=%0d exp=8", t, remaining[1*W +: W]); end
    end
    pulse_tick();
    checks++; if (remaining[1*W +: W] !== 8'd7) begin failures++; $display("FAIL pause_resume got=%0d exp=7", remaining[1*W +: W]); end
    // pause and tick together: pause wins
    pause[1] = 1'b1; pulse_tick(); pause = '0;
    checks++; if (remaining[1*W +: W] !== 8'd7) begin failures++; $display("FAIL pause_vs_tick got=%0d exp=7", remaining[1*W +: W]); end
    save[1] = 1'b1; tick_clk(); save = '0;
    checks++; if (saved[1] !== 1'b1) begin failures++; $display("FAIL pause_save got=%b exp=1", saved[1]); end
    clear[1] = 1'b1; tick_clk(); clear = '0;
  endtask

  task automatic test_save_at_zero();
    load_val[2*W +: W] = 8'd2; arm[2] = 1'b1;
    tick_clk(); arm = '0; tick_clk();
    pulse_tick(); pulse_tick();
    save[2] = 1'b1; tick_clk(); save = '0;
    checks++; if (saved[2] !== 1'b1) begin failures++; $display("FAIL s0_saved got=%b exp=1", saved[2]); end
    checks++; if (explode[2] !== 1'b0) begin failures++; $display("FAIL s0_explode got=%b exp=0", explode[2]); end
    checks++; if (active[2] !== 1'b0) begin failures++; $display("FAIL s0_active got=%b exp=0", active[2]); end
    clear[2] = 1'b1; tick_clk(); clear = '0;
    checks++; if (saved[2] !== 1'b0) begin failures++; $display("FAIL s0_clear got=%b exp=0", saved[2]); end
    checks++; if (remaining[2*W +: W] !== 8'd0) begin failures++; $display("FAIL s0_remaining got=%0d exp=0", remaining[2*W +: W]); end
  endtask

  task automatic test_zero_load();
    load_val[3*W +: W] = 8'd0; arm[3] = 1'b1;
    tick_clk(); arm = '0;
    checks++; if (explode[3] !== 1'b0) begin failures++; $display("FAIL z_c1 got=%b exp=0", explode[3]); end
    tick_clk();
    checks++; if (explode[3] !== 1'b0) begin failures++; $display("FAIL z_c2 got=%b exp=0", explode[3]); end
    tick_clk();
    checks++; if (explode[3] !== 1'b1) begin failures++; $display("FAIL z_c3 got=%b exp=1", explode[3]); end
    load_val[3*W +: W] = 8'd9; arm[3] = 1'b1; tick_clk(); arm = '0;
    checks++; if (explode[3] !== 1'b1) begin failures++; $display("FAIL z_rearm_state got=%b exp=1", explode[3]); end
    checks++; if (remaining[3*W +: W] !== 8'd0) begin failures++; $display("FAIL z_rearm_count got=%0d exp=0", remaining[3*W +: W]); end
    clear[3] = 1'b1; tick_clk(); clear = '0;
    checks++; if (explode[3] !== 1'b0) begin failures++; $display("FAIL z_clear got=%b exp=0", explode[3]); end
  endtask

  task automatic test_random();
    reset = 1'b1; idle_inputs(); tick_clk(); reset = 1'b0;
    arm = '1;
    for (int k = 0; k < N; k++) load_val[k*W +: W] = W'(5 + k);
    for (int c = 0; c < 500; c++) begin
      tick_clk();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (remaining[k*W +: W] !== W'(m_cnt[k])) begin failures++; $display("FAIL rand_remaining[%0d] cyc%0d got=%0d exp=%0d", k, c, remaining[k*W +: W], m_cnt[k]); end
        checks++;
        if (active[k] !== (m_ph[k] == P_ARM || m_ph[k] == P_RUN || m_ph[k] == P_PAUSE)) begin failures++; $display("FAIL rand_active[%0d] cyc%0d got=%b exp_phase=%0d", k, c, active[k], m_ph[k]); end
        checks++;
        if (explode[k] !== (m_ph[k] == P_BOOM)) begin failures++; $display("FAIL rand_explode[%0d] cyc%0d got=%b exp_phase=%0d", k, c, explode[k], m_ph[k]); end
        checks++;
        if (saved[k] !== (m_ph[k] == P_SAFE)) begin failures++; $display("FAIL rand_saved[%0d] cyc%0d got=%b exp_phase=%0d", k, c, saved[k], m_ph[k]); end
      end
      checks++;
      if (any_explode !== m_any) begin failures++; $display("FAIL rand_any cyc%0d got=%b exp=%b", c, any_explode, m_any); end
      reset       = ($urandom_range(0, 199) == 0);
      OneSecPulse = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        arm[k]   = ($urandom_range(0, 3) == 0);
        load_val[k*W +: W] = W'($urandom_range(0, 9));
        pause[k] = ($urandom_range(0, 7) == 0);
        save[k]  = ($urandom_range(0, 39) == 0);
        clear[k] = ($urandom_range(0, 3) == 0);
      end
    end
    reset = 1'b0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_save_at_zero();
    test_zero_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
